rv32_trap_unit: RTL

Precise trap and interrupt sequencer for the rv32 core. It sits directly upstream of the CSR bank and watches the writeback stage for retiring instructions. At an instruction boundary it decides to take an interrupt, an ecall/ebreak, or an mret, and drives the CSR bank's `interrupt_request` and mcause write. In the same cycle it redirects and flushes the pipeline, then holds off new traps until the pipeline has refilled.

---
 rtl/rv32_trap_unit_if.sv | 49 ++++
 rtl/rv32_trap_unit.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/rv32_trap_unit_if.sv
// Shared trap types and the writeback/trap interface between the pipeline and the trap unit.
// The pipeline side is the master; the trap unit is the slave.

package rv32_trap_pkg;

   typedef struct packed {
      logic [18:0] rsv_31_13;
      logic [1:0]  mpp;
      logic [2:0]  rsv_10_8;
      logic        mpie;
      logic [2:0]  rsv_6_4;
      logic        mie;
      logic [2:0]  rsv_2_0;
   } mstatus_t;

   typedef struct packed {
      logic        do_interrupt;
      logic        is_mret;
      logic [31:0] from;
   } interrupt_request_t;

endpackage

interface rv32_trap_unit_if;

   logic                              wb_valid;
   logic [31:0]                       wb_pc;
   logic [31:0]                       wb_next_pc;
   logic                              wb_is_ecall;
   logic                              wb_is_ebreak;
   logic                              wb_is_mret;
   rv32_trap_pkg::interrupt_request_t interrupt_request;
   logic                              mcause_write;
   logic [31:0]                       mcause_value;
   logic                              redirect_valid;
   logic [31:0]                       redirect_pc;
   logic                              flush;

   modport master (
      output wb_valid, wb_pc, wb_next_pc, wb_is_ecall, wb_is_ebreak, wb_is_mret,
      input  interrupt_request, mcause_write, mcause_value, redirect_valid, redirect_pc, flush
   );

   modport slave (
      input  wb_valid, wb_pc, wb_next_pc, wb_is_ecall, wb_is_ebreak, wb_is_mret,
      output interrupt_request, mcause_write, mcause_value, redirect_valid, redirect_pc, flush
   );

endinterface

// File: rtl/rv32_trap_unit.sv
// Precise trap/interrupt sequencer: picks ecall/ebreak/mret/interrupt at a retirement boundary,
// redirects and flushes in the same cycle, then holds off further traps while the pipe refills.

module rv32_trap_unit
   import rv32_trap_pkg::*;
#(
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned FLUSH_CYCLES = 3
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             irq_ext_i,
   input  logic             irq_timer_i,
   input  mstatus_t         mstatus_i,
   input  logic [31:0]      mtvec_i,
   input  logic [31:0]      mepc_i,
   rv32_trap_unit_if.slave  trap_if,
   output logic             trap_busy_o
);

   localparam logic [2:0]  HoldInit   = 3'(FLUSH_CYCLES - 1);
   localparam logic [31:0] CauseEcall = 32'd11;
   localparam logic [31:0] CauseEbrk  = 32'd3;
   localparam logic [31:0] CauseExt   = 32'h8000_000B;
   localparam logic [31:0] CauseTim   = 32'h8000_0007;
   localparam logic [31:0] VecOffExt  = 32'd44;
   localparam logic [31:0] VecOffTim  = 32'd28;

   typedef enum logic [0:0] {StIdle, StHold} state_e;

   state_e                 state_q;
   logic [2:0]             hcnt_q;
   logic                   busy_q;
   logic [SYNC_STAGES-1:0] sync_q;

   logic        ext_s;
   logic        pend_ext;
   logic        pend_tim;
   logic [31:0] vec_base;
   logic        take;
   logic        is_mret;
   logic        mcause_we;
   logic [31:0] cause;
   logic [31:0] from_pc;
   logic [31:0] target;
   logic        unused_bits;

   assign ext_s    = sync_q[SYNC_STAGES-1];
   assign pend_ext = ext_s & mstatus_i.mie;
   assign pend_tim = irq_timer_i & mstatus_i.mie;
   assign vec_base = {mtvec_i[31:2], 2'b00};

   // Only mie, the aligned mtvec base and the aligned mepc are architecturally meaningful here.
   assign unused_bits = ^{mstatus_i, mtvec_i[1], mepc_i[1:0]};

   always_comb begin
      take      = 1'b0;
      is_mret   = 1'b0;
      mcause_we = 1'b0;
      cause     = '0;
      from_pc   = '0;
      target    = '0;
      if (resetn && (state_q == StIdle) && trap_if.wb_valid) begin
         if (trap_if.wb_is_ecall) begin
            take      = 1'b1;
            mcause_we = 1'b1;
            cause     = CauseEcall;
            from_pc   = trap_if.wb_pc;
            target    = vec_base;
         end else if (trap_if.wb_is_ebreak) begin
            take      = 1'b1;
            mcause_we = 1'b1;
            cause     = CauseEbrk;
            from_pc   = trap_if.wb_pc;
            target    = vec_base;
         end else if (trap_if.wb_is_mret) begin
            take      = 1'b1;
            is_mret   = 1'b1;
            from_pc   = trap_if.wb_pc;
            target    = {mepc_i[31:2], 2'b00};
         end else if (pend_ext) begin
            // Interrupts retire the current instruction, so mepc gets the next PC.
            take      = 1'b1;
            mcause_we = 1'b1;
            cause     = CauseExt;
            from_pc   = trap_if.wb_next_pc;
            target    = mtvec_i[0] ? vec_base + VecOffExt : vec_base;
         end else if (pend_tim) begin
            take      = 1'b1;
            mcause_we = 1'b1;
            cause     = CauseTim;
            from_pc   = trap_if.wb_next_pc;
            target    = mtvec_i[0] ? vec_base + VecOffTim : vec_base;
         end
      end
   end

   assign trap_if.interrupt_request.do_interrupt = take;
   assign trap_if.interrupt_request.is_mret      = is_mret;
   assign trap_if.interrupt_request.from         = from_pc;
   assign trap_if.mcause_write                   = mcause_we;
   assign trap_if.mcause_value                   = cause;
   assign trap_if.redirect_valid                 = take;
   assign trap_if.redirect_pc                    = target;
   assign trap_if.flush                          = take;
   assign trap_busy_o                            = busy_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= StIdle;
         hcnt_q  <= '0;
         busy_q  <= 1'b0;
         sync_q  <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], irq_ext_i};
         unique case (state_q)
            StIdle: begin
               if (take) begin
                  state_q <= StHold;
                  hcnt_q  <= HoldInit;
                  busy_q  <= 1'b1;
               end
            end
            StHold: begin
               if (hcnt_q == 3'd0) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end else begin
                  hcnt_q <= hcnt_q - 3'd1;
               end
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule
